// File: rtl/matmul_tile_ctrl.sv
// matmul_tile_ctrl: control path for the tiled MAC array.
// Sequences cfg_tiles output tiles of a cfg_k-deep dot product: clear the
// accumulators, stream operand beats (stall-tolerant), flush the MAC pipeline,
// then hold the result tile until writeback accepts it.
module matmul_tile_ctrl #(
    parameter  int K_MAX    = 16,
    parameter  int T_MAX    = 8,
    parameter  int PIPE_LAT = 2,
    localparam int KW       = $clog2(K_MAX + 1),
    localparam int TW       = $clog2(T_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [KW-1:0] cfg_k,
    input  logic [TW-1:0] cfg_tiles,
    input  logic          abort,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          en,
    output logic          clear,
    output logic [KW-1:0] k,
    output logic [TW-1:0] tile,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);
    localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_FLUSH,
        S_OUT,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [KW-1:0] cfg_k_q;
    logic [TW-1:0] cfg_t_q;
    logic [FW-1:0] fcnt;
    logic          clear_q;
    logic          out_valid_q;
    logic          cfg_ok;
    logic          last_k;
    logic          last_t;

    assign cfg_ok = (cfg_k != '0) && (cfg_k <= KW'(K_MAX)) &&
                    (cfg_tiles != '0) && (cfg_tiles <= TW'(T_MAX));
    assign last_k = (k == cfg_k_q - KW'(1));
    assign last_t = (tile == cfg_t_q - TW'(1));

    // Abort suppresses the beat, the clear and the result tile in its own cycle.
    assign en        = in_valid & in_ready & ~abort;
    assign clear     = clear_q & ~abort;
    assign out_valid = out_valid_q & ~abort;

    // Next-state selection; abort overrides every transition outside IDLE/DONE.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:  if (start) state_n = cfg_ok ? S_CLEAR : S_DONE;
            S_CLEAR: state_n = S_RUN;
            S_RUN:   if (en && last_k) state_n = S_FLUSH;
            S_FLUSH: if (fcnt == FW'(PIPE_LAT - 1)) state_n = S_OUT;
            S_OUT:   if (out_ready) state_n = last_t ? S_DONE : S_CLEAR;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
        if (abort && state != S_IDLE && state != S_DONE) state_n = S_DONE;
    end

    // State register, registered control outputs and the k/tile/flush counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cfg_k_q     <= '0;
            cfg_t_q     <= '0;
            fcnt        <= '0;
            k           <= '0;
            tile        <= '0;
            in_ready    <= 1'b0;
            clear_q     <= 1'b0;
            out_valid_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            state       <= state_n;
            in_ready    <= (state_n == S_RUN);
            clear_q     <= (state_n == S_CLEAR);
            out_valid_q <= (state_n == S_OUT);
            busy        <= (state_n != S_IDLE);
            done        <= (state_n == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_k_q <= cfg_k;
                        cfg_t_q <= cfg_tiles;
                        err     <= ~cfg_ok;
                        tile    <= '0;
                        k       <= '0;
                    end
                end
                S_CLEAR: k <= '0;
                S_RUN: begin
                    if (en && !last_k) k <= k + KW'(1);
                    fcnt <= '0;
                end
                S_FLUSH: fcnt <= fcnt + FW'(1);
                S_OUT: begin
                    if (state_n == S_CLEAR) begin
                        tile <= tile + TW'(1);
                        k    <= '0;
                    end
                end
                default: ;
            endcase
            if (abort && state != S_IDLE) err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_matmul_tile_ctrl.sv
// tb_matmul_tile_ctrl: scoreboard bench for matmul_tile_ctrl.
// Expected operand beats (k, tile) and result tiles are queued when a job is
// launched and popped as the DUT produces en beats and out handshakes.
`timescale 1ns/1ps
module tb_matmul_tile_ctrl;
    localparam int K_MAX    = 16;
    localparam int T_MAX    = 8;
    localparam int PIPE_LAT = 2;
    localparam int KW       = $clog2(K_MAX + 1);
    localparam int TW       = $clog2(T_MAX + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic [TW-1:0] cfg_tiles = '0;
    logic          in_ready, en, clear, out_valid, busy, done, err;
    logic [KW-1:0] k;
    logic [TW-1:0] tile;

    int tests = 0;
    int fails = 0;
    int exp_en_k[$];
    int exp_en_t[$];
    int exp_out_t[$];
    int n_clear, n_en, n_done;
    int c_clear_first, c_clear_last, c_en_first, c_en_last, c_ov_first, c_done;
    int err_done, err_c1;
    int k_tr[0:255];

    matmul_tile_ctrl #(.K_MAX(K_MAX), .T_MAX(T_MAX), .PIPE_LAT(PIPE_LAT)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_tiles(cfg_tiles),
        .abort(abort), .in_valid(in_valid), .in_ready(in_ready), .en(en),
        .clear(clear), .k(k), .tile(tile), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Launch one job at cycle 0 and observe it until done or the cycle budget runs out.
    // in_valid is low for cycles st_lo..st_hi; out_ready is low for the first
    // ordy_low out_valid cycles; noise re-drives start with junk config mid-job.
    task automatic run_job(input int ck, input int ct, input int st_lo, input int st_hi,
                           input int ordy_low, input bit noise, input int budget);
        int cyc, ov_seen, ek, et;
        bit prev_hold, fin, good;
        logic [TW-1:0] prev_tile;
        logic [KW-1:0] prev_k;
        n_clear = 0; n_en = 0; n_done = 0;
        c_clear_first = -1; c_clear_last = -1; c_en_first = -1; c_en_last = -1;
        c_ov_first = -1; c_done = -1; err_done = -1; err_c1 = -1;
        good = (ck >= 1) && (ck <= K_MAX) && (ct >= 1) && (ct <= T_MAX);
        if (good) begin
            for (int t = 0; t < ct; t++) begin
                for (int kk = 0; kk < ck; kk++) begin
                    exp_en_k.push_back(kk);
                    exp_en_t.push_back(t);
                end
                exp_out_t.push_back(t);
            end
        end
        cyc = 0; ov_seen = 0; prev_hold = 0; fin = 0;
        prev_tile = '0; prev_k = '0;
        cfg_k = KW'(ck); cfg_tiles = TW'(ct); start = 1'b1;
        while (!fin && cyc <= budget) begin
            in_valid  = !(cyc >= st_lo && cyc <= st_hi);
            out_ready = (ov_seen >= ordy_low);
            @(negedge clk);
            if (cyc < 256) k_tr[cyc] = int'(k);
            if (cyc == 1) err_c1 = int'(err);
            tests++;
            if ((clear && en) || (done && en) || (out_valid && en)) begin
                fails++;
                $display("FAIL invariant cyc=%0d clear=%b en=%b done=%b out_valid=%b required en exclusive",
                         cyc, clear, en, done, out_valid);
            end
            tests++;
            if (busy !== (cyc >= 1)) begin
                fails++;
                $display("FAIL busy cyc=%0d got=%b required=%b", cyc, busy, (cyc >= 1));
            end
            if (clear) begin
                n_clear++;
                if (c_clear_first < 0) c_clear_first = cyc;
                c_clear_last = cyc;
            end
            if (en) begin
                n_en++;
                if (c_en_first < 0) c_en_first = cyc;
                c_en_last = cyc;
                tests++;
                if (exp_en_k.size() == 0) begin
                    fails++;
                    $display("FAIL en_unexpected cyc=%0d got k=%0d tile=%0d required no beat", cyc, k, tile);
                end else begin
                    ek = exp_en_k.pop_front();
                    et = exp_en_t.pop_front();
                    if (k !== KW'(ek) || tile !== TW'(et)) begin
                        fails++;
                        $display("FAIL en_beat cyc=%0d got k=%0d tile=%0d required k=%0d tile=%0d",
                                 cyc, k, tile, ek, et);
                    end
                end
            end
            if (out_valid) begin
                if (c_ov_first < 0) c_ov_first = cyc;
                if (prev_hold) begin
                    tests++;
                    if (tile !== prev_tile || k !== prev_k) begin
                        fails++;
                        $display("FAIL out_hold cyc=%0d got tile=%0d k=%0d required tile=%0d k=%0d",
                                 cyc, tile, k, prev_tile, prev_k);
                    end
                end
                if (out_ready) begin
                    tests++;
                    if (exp_out_t.size() == 0) begin
                        fails++;
                        $display("FAIL out_unexpected cyc=%0d got tile=%0d required no tile", cyc, tile);
                    end else begin
                        et = exp_out_t.pop_front();
                        if (tile !== TW'(et)) begin
                            fails++;
                            $display("FAIL out_tile cyc=%0d got=%0d required=%0d", cyc, tile, et);
                        end
                    end
                end
                prev_hold = !out_ready;
                prev_tile = tile;
                prev_k    = k;
                ov_seen++;
            end else begin
                prev_hold = 0;
            end
            if (done) begin
                n_done++;
                c_done   = cyc;
                err_done = int'(err);
                fin      = 1;
            end
            @(posedge clk); #1;
            cyc++;
            start = noise && (cyc >= 3) && (cyc <= 6);
            if (noise && cyc >= 3) begin
                cfg_k = KW'(1);
                cfg_tiles = TW'(1);
            end
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        if (!fin) begin
            tests++; fails++;
            $display("FAIL timeout got no done within %0d cycles required done", budget);
        end
        tests++;
        if (exp_en_k.size() != 0 || exp_out_t.size() != 0) begin
            fails++;
            $display("FAIL leftover got %0d beats %0d tiles outstanding required 0 0",
                     exp_en_k.size(), exp_out_t.size());
        end
        exp_en_k.delete(); exp_en_t.delete(); exp_out_t.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests++;
        if ({in_ready, en, clear, out_valid, busy, done, err} !== 7'b0 || k !== '0 || tile !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %b k=%0d tile=%0d required all 0",
                     {in_ready, en, clear, out_valid, busy, done, err}, k, tile);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if ({in_ready, en, clear, out_valid, busy, done, err} !== 7'b0) begin
            fails++;
            $display("FAIL reset_release got %b required all 0",
                     {in_ready, en, clear, out_valid, busy, done, err});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run_job(4, 1, -1, -1, 0, 0, 40);
        tests++;
        if (c_clear_first != 1 || n_clear != 1 || c_en_first != 2 || c_en_last != 5 || n_en != 4) begin
            fails++;
            $display("FAIL single_timing got clear@%0d x%0d en@%0d..%0d x%0d required clear@1 x1 en@2..5 x4",
                     c_clear_first, n_clear, c_en_first, c_en_last, n_en);
        end
        tests++;
        if (c_ov_first != 8 || c_done != 9 || n_done != 1 || err_done != 0) begin
            fails++;
            $display("FAIL single_out got out_valid@%0d done@%0d x%0d err=%0d required 8 9 x1 err=0",
                     c_ov_first, c_done, n_done, err_done);
        end
    endtask

    task automatic test_multi_tile();
        run_job(3, 3, -1, -1, 0, 1, 60);
        tests++;
        if (n_clear != 3 || n_en != 9 || n_done != 1 || c_ov_first != 7 || c_done != 22) begin
            fails++;
            $display("FAIL multi_tile got clears=%0d en=%0d dones=%0d ov@%0d done@%0d required 3 9 1 7 22",
                     n_clear, n_en, n_done, c_ov_first, c_done);
        end
    endtask

    task automatic test_stall();
        run_job(4, 1, 3, 4, 0, 0, 40);
        tests++;
        if (n_en != 4 || k_tr[3] != 1 || k_tr[4] != 1 || c_ov_first != 10 || c_done != 11) begin
            fails++;
            $display("FAIL stall got en=%0d k@3=%0d k@4=%0d ov@%0d done@%0d required 4 1 1 10 11",
                     n_en, k_tr[3], k_tr[4], c_ov_first, c_done);
        end
    endtask

    task automatic test_backpressure();
        run_job(3, 2, -1, -1, 5, 0, 60);
        tests++;
        if (n_clear != 2 || c_ov_first != 7 || c_clear_last != 13 || c_done != 20) begin
            fails++;
            $display("FAIL backpressure got clears=%0d ov@%0d clear2@%0d done@%0d required 2 7 13 20",
                     n_clear, c_ov_first, c_clear_last, c_done);
        end
    endtask

    task automatic test_bad_cfg();
        int ck_tab[2];
        int ct_tab[2];
        ck_tab[0] = 0; ct_tab[0] = 1;
        ck_tab[1] = 4; ct_tab[1] = T_MAX + 1;
        for (int i = 0; i < 2; i++) begin
            run_job(ck_tab[i], ct_tab[i], -1, -1, 0, 0, 10);
            tests++;
            if (n_clear != 0 || n_en != 0 || n_done != 1 || c_done < 1 || c_done > 2 || err_done != 1) begin
                fails++;
                $display("FAIL bad_cfg%0d got clears=%0d en=%0d dones=%0d done@%0d err=%0d required 0 0 1 1..2 1",
                         i, n_clear, n_en, n_done, c_done, err_done);
            end
            repeat (3) @(posedge clk);
            @(negedge clk);
            tests++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                fails++;
                $display("FAIL bad_cfg_sticky%0d got err=%b busy=%b required err=1 busy=0", i, err, busy);
            end
            @(posedge clk); #1;
        end
        run_job(2, 2, -1, -1, 0, 0, 40);
        tests++;
        if (err_c1 != 0 || err_done != 0 || n_done != 1 || n_en != 4 || c_done != 13) begin
            fails++;
            $display("FAIL err_clear got err@1=%0d err@done=%0d dones=%0d en=%0d done@%0d required 0 0 1 4 13",
                     err_c1, err_done, n_done, n_en, c_done);
        end
    endtask

    task automatic test_abort();
        cfg_k = KW'(4); cfg_tiles = TW'(1);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        abort = 1'b1;
        @(negedge clk);
        tests++;
        if (k !== KW'(2) || en !== 1'b0 || clear !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL abort_cycle got k=%0d en=%b clear=%b done=%b required k=2 en=0 clear=0 done=0",
                     k, en, clear, done);
        end
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        tests++;
        if (done !== 1'b1 || err !== 1'b1 || en !== 1'b0 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL abort_done got done=%b err=%b en=%b out_valid=%b required 1 1 0 0",
                     done, err, en, out_valid);
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL abort_idle got busy=%b done=%b err=%b required 0 0 1", busy, done, err);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_mid_flush();
        bit saw_done;
        cfg_k = KW'(4); cfg_tiles = TW'(1);
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        @(negedge clk);
        tests++;
        if (busy !== 1'b1 || en !== 1'b0 || out_valid !== 1'b0 || clear !== 1'b0) begin
            fails++;
            $display("FAIL flush_state got busy=%b en=%b out_valid=%b clear=%b required 1 0 0 0",
                     busy, en, out_valid, clear);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({in_ready, en, clear, out_valid, busy, done, err} !== 7'b0 || k !== '0 || tile !== '0) begin
            fails++;
            $display("FAIL rst_async got %b k=%0d tile=%0d required all 0",
                     {in_ready, en, clear, out_valid, busy, done, err}, k, tile);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        saw_done = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) saw_done = 1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL rst_no_done got done/busy after reset required idle");
        end
        @(posedge clk); #1;
        run_job(2, 1, -1, -1, 0, 0, 30);
        tests++;
        if (n_en != 2 || n_done != 1 || c_ov_first != 6 || c_done != 7 || err_done != 0) begin
            fails++;
            $display("FAIL rst_restart got en=%0d dones=%0d ov@%0d done@%0d err=%0d required 2 1 6 7 0",
                     n_en, n_done, c_ov_first, c_done, err_done);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi_tile();
        test_stall();
        test_backpressure();
        test_bad_cfg();
        test_abort();
        test_rst_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got no summary by 100us required bench completion");
        $fatal(1, "watchdog");
    end
endmodule
